// File: rtl/modular_half_iter.sv
// Iterative modular halving: y = x * 2^-k mod q, two 12-bit Kyber lanes or one Dilithium lane.
// Optional input reduction on capture is enabled by defining MODHALF_INPUT_REDUCE_EN.
module modular_half_iter #(
  parameter int DATA_WIDTH = 24,
  parameter int K_Q        = 3329,
  parameter int D_Q        = 8380417,
  parameter int SHIFT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  KD_mode,
  input  logic [SHIFT_W-1:0]    shift_k,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  busy
);

  localparam int LANE_W = DATA_WIDTH / 2;
  localparam logic [LANE_W-1:0]     K_HALF = LANE_W'((K_Q + 1) / 2);
  localparam logic [DATA_WIDTH-1:0] D_HALF = DATA_WIDTH'((D_Q + 1) / 2);
`ifdef MODHALF_INPUT_REDUCE_EN
  localparam logic [LANE_W-1:0]     K_Q_L  = LANE_W'(K_Q);
  localparam logic [DATA_WIDTH-1:0] D_Q_W  = DATA_WIDTH'(D_Q);
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHIFT_W-1:0]    cnt_q, cnt_d;
  logic                  mode_q, mode_d;

  logic [DATA_WIDTH-1:0] k_cap, k_step;
  logic [DATA_WIDTH-1:0] d_cap, d_step;

  // Kyber lanes are fully independent: each lane halves within its own 12 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [LANE_W-1:0] x_l;
      logic [LANE_W-1:0] a_l;
      assign x_l = x_in[gi*LANE_W +: LANE_W];
      assign a_l = acc_q[gi*LANE_W +: LANE_W];
`ifdef MODHALF_INPUT_REDUCE_EN
      assign k_cap[gi*LANE_W +: LANE_W] = (x_l >= K_Q_L) ? (x_l - K_Q_L) : x_l;
`else
      assign k_cap[gi*LANE_W +: LANE_W] = x_l;
`endif
      assign k_step[gi*LANE_W +: LANE_W] = a_l[0] ? ((a_l >> 1) + K_HALF) : (a_l >> 1);
    end
  endgenerate

`ifdef MODHALF_INPUT_REDUCE_EN
  assign d_cap = (x_in >= D_Q_W) ? (x_in - D_Q_W) : x_in;
`else
  assign d_cap = x_in;
`endif
  // Odd values add (q+1)/2, which is the modular inverse of 2 applied to the dropped bit.
  assign d_step = acc_q[0] ? ((acc_q >> 1) + D_HALF) : (acc_q >> 1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = KD_mode ? d_cap : k_cap;
          mode_d  = KD_mode;
          cnt_d   = shift_k;
          state_d = (shift_k == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        acc_d = mode_q ? d_step : k_step;
        cnt_d = cnt_q - SHIFT_W'(1);
        if (cnt_q == SHIFT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign y_out = acc_q;

endmodule

// File: tb/tb_modular_half_iter.sv
// Self-checking bench for modular_half_iter: directed vector table, corner sequences, random vs. model.
module tb_modular_half_iter;

  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] x_in;
  logic        KD_mode;
  logic [3:0]  shift_k;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] y_out;
  logic        busy;

  int tests;
  int fails;

  modular_half_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .KD_mode   (KD_mode),
    .shift_k   (shift_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] x;
    logic        mode;
    logic [3:0]  k;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: x * inv(2)^k mod q, computed with plain modular arithmetic.
  function automatic longint lane_ref(input longint v, input longint q, input int k);
    longint inv2;
    longint r;
    inv2 = (q + 1) / 2;
    r = v % q;
    for (int i = 0; i < k; i++) r = (r * inv2) % q;
    return r;
  endfunction

  function automatic logic [23:0] model(input logic [23:0] x, input logic m, input logic [3:0] k);
    logic [23:0] y;
    if (m) begin
      y = 24'(lane_ref(longint'(x), DQ, int'(k)));
    end else begin
      y[23:12] = 12'(lane_ref(longint'(x[23:12]), KQ, int'(k)));
      y[11:0]  = 12'(lane_ref(longint'(x[11:0]), KQ, int'(k)));
    end
    return y;
  endfunction

  // Starts at a negedge; returns at the negedge where out_valid is first seen (or on timeout).
  task automatic do_txn(input logic [23:0] x, input logic m, input logic [3:0] k, input logic rdy,
                        output logic [23:0] y, output int lat, output bit ok);
    chk("in_ready_before_accept", in_ready, 1);
    x_in = x; KD_mode = m; shift_k = k; in_valid = 1'b1; out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0; KD_mode = ~m; shift_k = ~k; x_in = 24'($urandom);
    lat = 0; ok = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    y = y_out;
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  logic [23:0] y, e, held;
  int          lat;
  bit          ok;
  int          vcnt;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; KD_mode = 1'b0; shift_k = '0; out_ready = 1'b0;

    vecs[0] = '{x: {12'd3328, 12'd1}, mode: 1'b0, k: 4'd1, exp: {12'd1664, 12'd1665}};
    vecs[1] = '{x: 24'd1,             mode: 1'b1, k: 4'd8, exp: 24'd8347681};
    vecs[2] = '{x: {12'd1, 12'd1},    mode: 1'b0, k: 4'd7, exp: {12'd3303, 12'd3303}};
`ifdef MODHALF_INPUT_REDUCE_EN
    vecs[3] = '{x: {12'd5, 12'd3334}, mode: 1'b0, k: 4'd0, exp: {12'd5, 12'd5}};
`else
    vecs[3] = '{x: {12'd5, 12'd3334}, mode: 1'b0, k: 4'd0, exp: {12'd5, 12'd3334}};
`endif
    vecs[4] = '{x: 24'd8380416,       mode: 1'b1, k: 4'd1, exp: 24'd4190208};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y_out", y_out, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      do_txn(vecs[i].x, vecs[i].mode, vecs[i].k, 1'b0, y, lat, ok);
      $display("[TB] vec %0d mode=%0d k=%0d x=0x%06h y=0x%06h exp=0x%06h lat=%0d",
               i, vecs[i].mode, vecs[i].k, vecs[i].x, y, vecs[i].exp, lat);
      chk("vec_y", y, vecs[i].exp);
      chk("vec_latency", lat, int'(vecs[i].k));
      chk("vec_busy_done", busy, 1);
      handshake();
    end

    // Backpressure: result held stable, new input ignored while DONE
    e = model({12'd100, 12'd7}, 1'b0, 4'd3);
    do_txn({12'd100, 12'd7}, 1'b0, 4'd3, 1'b0, held, lat, ok);
    chk("bp_y", held, e);
    $display("[TB] backpressure x=0x%06h y=0x%06h exp=0x%06h", {12'd100, 12'd7}, held, e);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; x_in = 24'($urandom); KD_mode = 1'b1; shift_k = 4'd2;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_y_stable", y_out, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    @(negedge clk);
    chk("bp_no_spurious_accept", busy, 0);

    // out_ready already high on DONE entry: one-cycle out_valid
    e = model({12'd11, 12'd2000}, 1'b0, 4'd2);
    do_txn({12'd11, 12'd2000}, 1'b0, 4'd2, 1'b1, y, lat, ok);
    $display("[TB] ready-high x=0x%06h y=0x%06h exp=0x%06h lat=%0d", {12'd11, 12'd2000}, y, e, lat);
    chk("rdyhi_y", y, e);
    chk("rdyhi_latency", lat, 2);
    @(negedge clk);
    chk("rdyhi_one_cycle", out_valid, 0);
    chk("rdyhi_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Reset pulse during BUSY
    x_in = 24'd1; KD_mode = 1'b1; shift_k = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy_in_ready", in_ready, 1);
    chk("rst_busy_out_valid", out_valid, 0);
    chk("rst_busy_y_out", y_out, 0);
    chk("rst_busy_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(24'd2, 1'b1, 4'd1, 1'b0, y, lat, ok);
    $display("[TB] post-reset x=2 k=1 y=%0d lat=%0d", y, lat);
    chk("post_reset_y", y, 1);
    chk("post_reset_latency", lat, 1);
    handshake();

    // Reset during DONE drops out_valid without a clock edge
    do_txn({12'd9, 12'd9}, 1'b0, 4'd1, 1'b0, y, lat, ok);
    chk("pre_async_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_y_out", y_out, 0);
    $display("[TB] async reset in DONE out_valid=%0d", out_valid);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        m;
      logic [3:0]  k;
      logic [23:0] x;
      m = 1'($urandom_range(0, 1));
      k = 4'($urandom_range(0, 15));
`ifdef MODHALF_INPUT_REDUCE_EN
      if (m) x = 24'($urandom_range(0, 2 * DQ - 1));
      else   x = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
`else
      if (m) x = 24'($urandom_range(0, DQ - 1));
      else   x = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
`endif
      e = model(x, m, k);
      do_txn(x, m, k, 1'b0, y, lat, ok);
      $display("[TB] rnd %0d mode=%0d k=%0d x=0x%06h y=0x%06h exp=0x%06h lat=%0d",
               n, m, k, x, y, e, lat);
      chk("rnd_y", y, e);
      chk("rnd_latency", lat, int'(k));
      vcnt = $urandom_range(0, 3);
      repeat (vcnt) @(negedge clk);
      chk("rnd_y_hold", y_out, e);
      handshake();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modular_half_iter.md
# modular_half_iter

Iterative, parametrised modular halving unit. It computes y = x·2^-k mod q for a per-transaction shift count k, applying k successive modular halvings. It runs as two packed 12-bit Kyber lanes (q = 3329) or one Dilithium lane (q = 8380417). It sits after the INTT butterfly array and applies the final n^-1 scaling, with a valid/ready handshake on both sides.

## Interface
- DATA_WIDTH, 24, packed word width; Kyber lanes are [23:12] and [11:0]
- K_Q, 3329, Kyber modulus
- D_Q, 8380417, Dilithium modulus
- SHIFT_W, 4, width of the shift count (k ≤ 2^SHIFT_W − 1)

Ports:
- clk  in  1  clock; one clock domain, all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word presented
- in_ready  out  1  block can accept an input
- x_in  in  DATA_WIDTH  operand; each lane in [0, q)
- KD_mode  in  1  0 = Kyber (2 lanes), 1 = Dilithium (1 lane); sampled on accept
- shift_k  in  SHIFT_W  number of halvings k; sampled on accept
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- y_out  out  DATA_WIDTH  result; Kyber {lane1, lane0}, Dilithium zero-extended
- busy  out  1  high in BUSY or DONE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. When in_valid is high, the block captures x_in, KD_mode and shift_k into acc, mode_r and cnt.
  - If shift_k = 0, next state is DONE.
  - Otherwise next state is BUSY.
- BUSY: each cycle applies one halving step to every active lane and decrements cnt. When cnt reaches 1, the state moves to DONE in the same cycle as the last step.
- DONE: out_valid = 1 and y_out = acc. The state holds until out_ready is high, then returns to IDLE.
- No overlap between transactions: in_ready = 0 in BUSY and DONE.
- Halving step per lane with modulus q:
  - if v is even, v' = v >> 1;
  - if v is odd, v' = (v >> 1) + (q+1)/2.
  - (q+1)/2 is 1665 for Kyber and 4190209 for Dilithium.
  - For v < q the result satisfies v' < q, so there is no carry out of the lane width.
- Kyber mode: lanes [23:12] and [11:0] are processed independently, with no carry between them.
- Dilithium mode: the full 24-bit word is processed; bit 23 of the result is 0.
- mode_r and cnt are frozen for the whole transaction. Changes on KD_mode or shift_k after accept have no effect.

## Timing
- Reset values: state = IDLE, acc = 0, cnt = 0, mode_r = 0. Outputs: in_ready = 1, out_valid = 0, y_out = 0, busy = 0.
- Accept at edge t, with k > 0: out_valid rises after edge t+k, i.e. latency is k+1 cycles to out_valid.
- Accept at edge t, with k = 0: out_valid is high in cycle t+1.
- Output handshake completes on the edge where out_valid && out_ready. in_ready is high in the following cycle.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.
- Back-to-back minimum period is k+2 cycles per transaction.
- Reset asserted mid-transaction: the block returns to the reset state immediately, the result is discarded and out_valid drops asynchronously.
- y_out is stable while out_valid && !out_ready.

## Configuration
- MODHALF_INPUT_REDUCE_EN
  - Defined: on accept, each lane is conditionally reduced before storing (v ≥ q ? v − q : v). This accepts inputs in [0, 2q) and guarantees outputs in [0, q). It adds no cycles, because the reduction is combinational on the capture path.
  - Undefined: x_in is stored unmodified. Inputs must be < q; for inputs ≥ q the output range is not guaranteed, but the result is still congruent to x·2^-k mod q.

## Test plan
- Kyber, x_in = {12'd3328, 12'd1}, k = 1 → y_out = {1664, 1665}. out_valid is high 2 cycles after accept.
- Dilithium, x_in = 1, k = 8 → y_out = 8347681 (the inverse of 256). out_valid is high 9 cycles after accept.
- Kyber, x_in = {12'd1, 12'd1}, k = 7 → y_out = {3303, 3303} (inverse of 128). Both lanes are identical, confirming there is no inter-lane carry.
- k = 0, Kyber x_in = {12'd5, 12'd3334}:
  - with the macro defined → y_out = {5, 5} one cycle after accept;
  - without it → y_out = {5, 3334}.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid.
  - y_out and out_valid stay stable; in_ready = 0 throughout.
  - A new in_valid is ignored until after the output handshake.
- Reset pulse during BUSY (Dilithium, k = 8, 3 cycles in) → outputs return to reset values. The next transaction (x = 2, k = 1) gives y_out = 1.
